// File: rtl/rv_pkg.sv
// Shared types and encodings for the multi-cycle RV32UI control path.
package rv_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CL_NONE, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_BRANCH, CL_LOAD,
    CL_STORE, CL_OPIMM, CL_OP, CL_FENCE, CL_SYSTEM
  } iclass_t;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MDR = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;

  localparam logic [1:0] HC_NONE    = 2'd0;
  localparam logic [1:0] HC_SYS     = 2'd1;
  localparam logic [1:0] HC_ILLEGAL = 2'd2;
  localparam logic [1:0] HC_TIMEOUT = 2'd3;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       retire;
    logic       halted;
  } ctl_t;

  // Control word for the state being entered; ALU selects stay up through
  // MEM and WB so the address / result / JALR target remain valid there.
  function automatic ctl_t ctl_for(state_t st, iclass_t cl, logic taken, logic rd_zero);
    ctl_t c;
    c = '0;
    case (st)
      ST_FETCH: c.imem_req = 1'b1;
      ST_EXEC, ST_MEM, ST_WB: begin
        case (cl)
          CL_LUI:   begin c.alu_a_sel = A_ZERO; c.alu_b_sel = B_IMM; end
          CL_AUIPC: begin c.alu_a_sel = A_PC;   c.alu_b_sel = B_IMM; end
          CL_OPIMM, CL_LOAD, CL_STORE, CL_JALR:
                    begin c.alu_a_sel = A_RS1;  c.alu_b_sel = B_IMM; end
          default:  begin c.alu_a_sel = A_RS1;  c.alu_b_sel = B_RS2; end
        endcase
        if (st == ST_MEM) begin
          c.dmem_req = 1'b1;
          c.dmem_we  = (cl == CL_STORE);
        end
        if (st == ST_WB) begin
          c.pc_we  = 1'b1;
          c.retire = 1'b1;
          case (cl)
            CL_JAL:    c.pc_sel = PC_IMM;
            CL_BRANCH: c.pc_sel = taken ? PC_IMM : PC_PLUS4;
            CL_JALR:   c.pc_sel = PC_JALR;
            default:   c.pc_sel = PC_PLUS4;
          endcase
          case (cl)
            CL_JAL, CL_JALR: c.wb_sel = WB_PC4;
            CL_LOAD:         c.wb_sel = WB_MDR;
            default:         c.wb_sel = WB_ALU;
          endcase
          case (cl)
            CL_LUI, CL_AUIPC, CL_JAL, CL_JALR, CL_LOAD, CL_OP, CL_OPIMM:
              c.rf_we = ~rd_zero;
            default: c.rf_we = 1'b0;
          endcase
        end
      end
      ST_HALT: c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv_opcode_decode.sv
// Combinational instruction classifier: opcode + funct3 -> class and legality.
module rv_opcode_decode
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_t     iclass,
  output logic        legal
);

  logic [2:0] f3;
  logic       unused_bits;

  assign f3          = instr[14:12];
  assign unused_bits = ^{instr[31:15], instr[11:7]};

  // Map the major opcode to a class, qualifying by funct3 where RV32I leaves holes.
  always_comb begin
    iclass = CL_NONE;
    legal  = 1'b0;
    case (instr[6:0])
      OPC_LUI:     begin iclass = CL_LUI;    legal = 1'b1; end
      OPC_AUIPC:   begin iclass = CL_AUIPC;  legal = 1'b1; end
      OPC_JAL:     begin iclass = CL_JAL;    legal = 1'b1; end
      OPC_JALR:    begin iclass = CL_JALR;   legal = (f3 == 3'b000); end
      OPC_BRANCH:  begin iclass = CL_BRANCH; legal = (f3 != 3'b010) && (f3 != 3'b011); end
      OPC_LOAD:    begin
        iclass = CL_LOAD;
        legal  = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 (f3 == 3'b100) || (f3 == 3'b101);
      end
      OPC_STORE:   begin iclass = CL_STORE;  legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010); end
      OPC_OPIMM:   begin iclass = CL_OPIMM;  legal = 1'b1; end
      OPC_OP:      begin iclass = CL_OP;     legal = 1'b1; end
      OPC_MISCMEM: begin iclass = CL_FENCE;  legal = 1'b1; end
      OPC_SYSTEM:  begin iclass = CL_SYSTEM; legal = 1'b1; end
      default:     begin iclass = CL_NONE;   legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
module rv_mc_ctrl
  import rv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [1:0]       halt_cause
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        state;
  iclass_t       cls;
  iclass_t       dec_class;
  logic          dec_legal;
  ctl_t          ctl;
  logic [TW-1:0] wait_cnt;
  logic          rd_zero;

  rv_opcode_decode u_dec (
    .instr  (instr),
    .iclass (dec_class),
    .legal  (dec_legal)
  );

  assign rd_zero = (instr[11:7] == 5'd0);

  assign imem_req  = ctl.imem_req;
  assign dmem_req  = ctl.dmem_req;
  assign dmem_we   = ctl.dmem_we;
  assign pc_we     = ctl.pc_we;
  assign pc_sel    = ctl.pc_sel;
  assign alu_a_sel = ctl.alu_a_sel;
  assign alu_b_sel = ctl.alu_b_sel;
  assign rf_we     = ctl.rf_we;
  assign wb_sel    = ctl.wb_sel;
  assign retire    = ctl.retire;
  assign halted    = ctl.halted;
  assign ir_we     = ctl.imem_req & imem_ready;
  assign mdr_we    = ctl.dmem_req & ~ctl.dmem_we & dmem_ready;

  // Sequencer: next state, registered class, control word, wait counter and retire count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cls        <= CL_NONE;
      ctl        <= '0;
      instret    <= '0;
      halt_cause <= HC_NONE;
      wait_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_FETCH;
          wait_cnt <= '0;
          ctl      <= ctl_for(ST_FETCH, cls, 1'b0, 1'b0);
        end
        ST_FETCH: begin
          if (imem_ready) begin
            state <= ST_DECODE;
            ctl   <= ctl_for(ST_DECODE, cls, 1'b0, 1'b0);
          end else if (wait_cnt == TO_LAST) begin
            state      <= ST_HALT;
            halt_cause <= HC_TIMEOUT;
            ctl        <= ctl_for(ST_HALT, cls, 1'b0, 1'b0);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DECODE: begin
          cls <= dec_class;
          if (dec_class == CL_SYSTEM) begin
            state      <= ST_HALT;
            halt_cause <= HC_SYS;
            ctl        <= ctl_for(ST_HALT, dec_class, 1'b0, 1'b0);
          end else if (!dec_legal) begin
            state      <= ST_HALT;
            halt_cause <= HC_ILLEGAL;
            ctl        <= ctl_for(ST_HALT, dec_class, 1'b0, 1'b0);
          end else begin
            state <= ST_EXEC;
            ctl   <= ctl_for(ST_EXEC, dec_class, 1'b0, 1'b0);
          end
        end
        ST_EXEC: begin
          if (cls == CL_LOAD || cls == CL_STORE) begin
            state    <= ST_MEM;
            wait_cnt <= '0;
            ctl      <= ctl_for(ST_MEM, cls, 1'b0, 1'b0);
          end else begin
            state <= ST_WB;
            ctl   <= ctl_for(ST_WB, cls, branch_taken, rd_zero);
          end
        end
        ST_MEM: begin
          if (dmem_ready) begin
            state <= ST_WB;
            ctl   <= ctl_for(ST_WB, cls, 1'b0, rd_zero);
          end else if (wait_cnt == TO_LAST) begin
            state      <= ST_HALT;
            halt_cause <= HC_TIMEOUT;
            ctl        <= ctl_for(ST_HALT, cls, 1'b0, 1'b0);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WB: begin
          state    <= ST_FETCH;
          wait_cnt <= '0;
          instret  <= instret + 1'b1;
          ctl      <= ctl_for(ST_FETCH, cls, 1'b0, 1'b0);
        end
        ST_HALT: ;
        default: begin
          state <= ST_IDLE;
          ctl   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Self-checking bench for rv_mc_ctrl with a queue-based scoreboard.
module tb_rv_mc_ctrl;

  localparam int TO    = 16;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        branch_taken = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, mdr_we, pc_we;
  logic [1:0]  pc_sel, alu_a_sel, wb_sel, halt_cause;
  logic        alu_b_sel, rf_we, retire, halted;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;
  int expInstret = 0;

  typedef struct {
    logic [31:0] ins;
    int          iw;
    int          dw;
    logic        taken;
    logic        halts;
    logic [1:0]  cause;
    logic [1:0]  pcSel;
    logic [1:0]  wbSel;
    logic        rfWe;
    int          cycles;
    int          dCyc;
    logic        dWe;
    logic        mdr;
  } exp_t;

  exp_t sbQ[$];

  rv_mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .retire(retire), .instret(instret),
    .halted(halted), .halt_cause(halt_cause)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [31:0] ins, int iw, int dw, logic taken, logic halts,
                              logic [1:0] cause, logic [1:0] pcs, logic [1:0] wbs, logic rfw,
                              int cyc, int dcyc, logic dwe, logic mdr);
    exp_t e;
    e.ins = ins; e.iw = iw; e.dw = dw; e.taken = taken; e.halts = halts; e.cause = cause;
    e.pcSel = pcs; e.wbSel = wbs; e.rfWe = rfw; e.cycles = cyc; e.dCyc = dcyc;
    e.dWe = dwe; e.mdr = mdr;
    return e;
  endfunction

  function automatic logic [17:0] ctlVec();
    return {imem_req, dmem_req, dmem_we, ir_we, mdr_we, pc_we, pc_sel, alu_a_sel,
            alu_b_sel, rf_we, wb_sel, retire, halted, halt_cause};
  endfunction

  // Hold reset, confirm everything is cleared, release and confirm IDLE->FETCH.
  task automatic doReset(input string nm);
    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput({nm, " reset ctl"}, 32'(ctlVec()), 32'h0);
    checkOutput({nm, " reset instret"}, instret, 32'h0);
    expInstret = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({nm, " fetch after idle"}, 32'(imem_req), 32'h1);
  endtask

  // Called with the DUT in FETCH just after a clock edge; plays both memories
  // and compares against the expectation pushed for this instruction.
  task automatic applyStimulus(input string nm, input exp_t e);
    exp_t x;
    int   cyc, iSeen, dSeen, dCyc;
    logic dWeBad, mdrSeen, rfEarly, both, done, hlt;
    logic [1:0] pcs, wbs;
    logic rfw;
    sbQ.push_back(e);
    instr = e.ins; branch_taken = e.taken;
    cyc = 0; iSeen = 0; dSeen = 0; dCyc = 0;
    dWeBad = 0; mdrSeen = 0; rfEarly = 0; both = 0; done = 0; hlt = 0;
    pcs = 0; wbs = 0; rfw = 0;
    while (!done && cyc < 200) begin
      cyc++;
      imem_ready = imem_req && (iSeen >= e.iw);
      if (imem_req) iSeen++;
      dmem_ready = dmem_req && (dSeen >= e.dw);
      if (dmem_req) dSeen++;
      #1;
      if (dmem_req) begin
        dCyc++;
        if (dmem_we !== e.dWe) dWeBad = 1;
      end
      if (mdr_we) mdrSeen = 1;
      if (imem_req && dmem_req) both = 1;
      if (rf_we && !retire) rfEarly = 1;
      if (retire) begin
        pcs = pc_sel; wbs = wb_sel; rfw = rf_we; done = 1;
      end else if (halted) begin
        hlt = 1; done = 1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    imem_ready = 1'b0; dmem_ready = 1'b0;
    x = sbQ.pop_front();
    checkOutput({nm, " finished"}, 32'(done), 32'h1);
    checkOutput({nm, " cycles"}, cyc, x.cycles);
    checkOutput({nm, " halted"}, 32'(hlt), 32'(x.halts));
    checkOutput({nm, " req overlap"}, 32'(both), 32'h0);
    if (x.halts) begin
      checkOutput({nm, " halt_cause"}, 32'(halt_cause), 32'(x.cause));
      checkOutput({nm, " halt reqs"}, {30'h0, imem_req, dmem_req}, 32'h0);
      checkOutput({nm, " halt instret"}, instret, expInstret);
    end else begin
      checkOutput({nm, " pc_sel"}, 32'(pcs), 32'(x.pcSel));
      checkOutput({nm, " wb_sel"}, 32'(wbs), 32'(x.wbSel));
      checkOutput({nm, " rf_we"}, 32'(rfw), 32'(x.rfWe));
      checkOutput({nm, " early rf_we"}, 32'(rfEarly), 32'h0);
      checkOutput({nm, " dmem cycles"}, dCyc, x.dCyc);
      checkOutput({nm, " dmem_we stable"}, 32'(dWeBad), 32'h0);
      checkOutput({nm, " mdr_we"}, 32'(mdrSeen), 32'(x.mdr));
      checkOutput({nm, " instret in WB"}, instret, expInstret);
      @(posedge clk);
      #1;
      expInstret++;
      checkOutput({nm, " instret"}, instret, expInstret);
      checkOutput({nm, " refetch"}, {30'h0, imem_req, retire}, 32'h2);
    end
  endtask

  initial begin
    doReset("r1");
    applyStimulus("addi x1",    mk(32'h00500093, 0, 0,     0, 0, 0, 0, 0, 1, 4, 0,  0, 0));
    applyStimulus("addi x0",    mk(32'h00500013, 0, 0,     0, 0, 0, 0, 0, 0, 4, 0,  0, 0));
    applyStimulus("lw 3 waits", mk(32'h01002083, 0, 3,     0, 0, 0, 0, 1, 1, 8, 4,  0, 1));
    applyStimulus("sw",         mk(32'h00002A23, 0, 0,     0, 0, 0, 0, 0, 0, 5, 1,  1, 0));
    applyStimulus("beq taken",  mk(32'h00000863, 0, 0,     1, 0, 0, 1, 0, 0, 4, 0,  0, 0));
    applyStimulus("bne fall",   mk(32'h00001863, 0, 0,     0, 0, 0, 0, 0, 0, 4, 0,  0, 0));
    applyStimulus("jal x0",     mk(32'h0010006F, 0, 0,     0, 0, 0, 1, 2, 0, 4, 0,  0, 0));
    applyStimulus("jalr x1",    mk(32'h000080E7, 0, 0,     0, 0, 0, 2, 2, 1, 4, 0,  0, 0));
    applyStimulus("lui x5",     mk(32'h123452B7, 0, 0,     0, 0, 0, 0, 0, 1, 4, 0,  0, 0));
    applyStimulus("fence",      mk(32'h0000000F, 0, 0,     0, 0, 0, 0, 0, 0, 4, 0,  0, 0));
    applyStimulus("add x3",     mk(32'h002081B3, 0, 0,     0, 0, 0, 0, 0, 1, 4, 0,  0, 0));
    applyStimulus("lw last",    mk(32'h01002083, 0, TO-1,  0, 0, 0, 0, 1, 1, 20, 16, 0, 1));
    applyStimulus("addi iwait", mk(32'h00500093, 2, 0,     0, 0, 0, 0, 0, 1, 6, 0,  0, 0));
    applyStimulus("load f3=3",  mk(32'h00003083, 0, 0,     0, 1, 2, 0, 0, 0, 3, 0,  0, 0));
    imem_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    imem_ready = 1'b0;
    checkOutput("halt sticky", {29'h0, halted, retire, imem_req}, 32'h4);
    checkOutput("halt cause sticky", 32'(halt_cause), 32'h2);
    checkOutput("halt instret frozen", instret, expInstret);

    doReset("r2");
    applyStimulus("illegal", mk(32'hFFFFFFFF, 0, 0, 0, 1, 2, 0, 0, 0, 3, 0, 0, 0));
    doReset("r3");
    applyStimulus("ecall",   mk(32'h00000073, 0, 0, 0, 1, 1, 0, 0, 0, 3, 0, 0, 0));
    doReset("r4");
    applyStimulus("lw timeout", mk(32'h01002083, 0, NEVER, 0, 1, 3, 0, 0, 0, 20, 0, 0, 0));

    doReset("r5");
    applyStimulus("addi pre", mk(32'h00500093, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0));
    instr = 32'h01002083;
    for (int k = 0; k < 10 && !dmem_req; k++) begin
      imem_ready = imem_req;
      @(posedge clk);
      #1;
    end
    imem_ready = 1'b0;
    checkOutput("mid-MEM dmem_req", 32'(dmem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async abort ctl", 32'(ctlVec()), 32'h0);
    checkOutput("async abort instret", instret, 32'h0);
    expInstret = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("restart fetch", 32'(imem_req), 32'h1);
    applyStimulus("addi post", mk(32'h00500093, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
